uart_fifo_bridge: RTL and testbench
===================================

Name: uart_fifo_bridge

Overview:
Parametrised full-duplex UART with a receive FIFO, configurable frame format and a runtime echo mode. In echo mode, received bytes are retransmitted from the FIFO head automatically. Otherwise, RX and TX are exposed to fabric logic through valid/ready handshakes. Sits between the board UART pins and user logic; replaces separate receiver/transmitter instances.

Parameters:
CLK_FREQ, 50000000, input clock frequency in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 4)
DATA_BITS, 8, data bits per frame, 5..9
FIFO_DEPTH, 16, RX FIFO entries, power of two, >= 2
STOP_BITS, 1, stop bits on TX, 1 or 2 (RX always checks one)

Ports:
CLOCK_50  in  1  system clock
KEY  in  1  reset, synchronous, active-low
uart_rxd  in  1  serial input, asynchronous, idle high
uart_txd  out  1  serial output, idle high
echo_en  in  1  1 = FIFO drains into TX; 0 = host interfaces active
tx_data  in  DATA_BITS  host byte to send
tx_valid  in  1  host TX request
tx_ready  out  1  TX accepts tx_data this cycle
rx_data  out  DATA_BITS  FIFO head
rx_valid  out  1  FIFO not empty and echo_en=0
rx_ready  in  1  host pop
rx_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
tx_busy  out  1  frame in progress on uart_txd
frame_err  out  1  sticky: stop bit sampled low
overrun  out  1  sticky: byte received while FIFO full
err_clr  in  1  clears all sticky flags

Behaviour:
- One clock: CLOCK_50. Reset: KEY, synchronous, active-low.
- While KEY=0 on a clock edge:
  - uart_txd=1; tx_busy=0; tx_ready=0.
  - rx_valid=0; rx_count=0; rx_data=0.
  - All flags=0.
  - Both FSMs go to IDLE. The FIFO is emptied.
  - Reset mid-frame aborts the frame immediately; the line returns high next cycle.
- RX input: uart_rxd passes through a 2-flop synchroniser.
- RX FSM: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on synchronised low.
  - START: sample at CLKS_PER_BIT/2. If high, treat as a glitch and return to IDLE. If low, go to DATA.
  - DATA: sample every CLKS_PER_BIT, LSB first, DATA_BITS samples. Then go to PARITY (feature on) or STOP.
  - STOP: sample once.
    - High: push the byte to the FIFO.
    - Low: set frame_err and discard the byte.
    - Either way, return to IDLE at that sample. This gives 0.5-bit resynchronisation margin.
- FIFO push when full: drop the byte, set overrun. Existing contents are unchanged.
- Simultaneous push and pop: both take effect. Occupancy is unchanged, even when the FIFO is full.
- Pointers wrap modulo FIFO_DEPTH. rx_count is registered and updates the cycle after a push or pop.
- rx_data: first-word fall-through; it shows the head whenever the FIFO is non-empty.
- Host pop: occurs when rx_valid & rx_ready.
- TX FSM: IDLE, START, DATA, PARITY, STOP; each state lasts CLKS_PER_BIT cycles.
  - STOP lasts STOP_BITS x CLKS_PER_BIT.
  - STOP returns to IDLE, after which a new frame may start the next cycle (back-to-back frames allowed).
- TX source when echo_en=0:
  - tx_ready=1 only in IDLE.
  - The handshake is tx_valid & tx_ready. It latches tx_data, and uart_txd goes low the following cycle.
- TX source when echo_en=1:
  - tx_ready=0 and rx_valid=0.
  - In IDLE with the FIFO non-empty, the FSM pops the head internally and starts a frame.
- echo_en is sampled only in TX IDLE. Toggling it mid-frame does not disturb the current frame.
- tx_busy=1 from START through the end of STOP.
- Sticky flags:
  - Set on the error event and held until err_clr=1.
  - err_clr in the same cycle as a new error: the set wins.

Optional Feature:
UART_PARITY_EN. When defined:
- Parameter PARITY_ODD (default 0) is added.
- TX inserts a parity bit after the data bits.
- RX samples the parity bit. On mismatch it sets parity_err (sticky, cleared by err_clr) and discards the byte.

When undefined:
- No parity bit is sent or expected.
- The parity_err port is absent.

Decomposition:
- Shared package uart_pkg holds:
  - the RX/TX state enum (IDLE, START, DATA, PARITY, STOP);
  - a function computing CLKS_PER_BIT and its counter width.
- One natural sub-module: sync_fifo (parameters WIDTH, DEPTH; first-word fall-through, count output). It is instantiated once for the RX FIFO and is reusable for a future TX FIFO.

Test Plan:
Use CLK_FREQ=1000000, BAUD=100000 (10 clks/bit), DATA_BITS=8, FIFO_DEPTH=4 unless stated.
1. Reset: hold KEY=0 mid-TX frame -> next cycle uart_txd=1, tx_busy=0, rx_count=0, all flags 0.
2. Host TX: tx_data=8'hA5, tx_valid=1 in IDLE -> uart_txd carries 0,1,0,1,0,0,1,0,1,1, each bit exactly 10 clks; tx_ready low throughout.
3. RX and read: drive 8'h3C on uart_rxd -> rx_valid=1, rx_data=8'h3C, rx_count=1 ~95 clks after the start edge. Pop with rx_ready -> rx_count=0.
4. Overrun: send 5 bytes 8'h01..8'h05 with no pops -> rx_count=4, overrun=1, head=8'h01, 8'h05 lost. err_clr -> overrun=0.
5. Framing: send 8'h55 with stop bit low; also send a 3-clk low glitch -> frame_err=1, FIFO unchanged, glitch ignored.
6. Echo: echo_en=1, send 8'hC3, 8'h7E back-to-back -> the same bytes appear on uart_txd in order; rx_valid stays 0; FIFO ends empty.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART bridge and its helpers.
//   uart_state_e     - common RX/TX frame state encoding
//   calc_clks_per_bit - clock cycles per serial bit (integer division)
//   calc_cnt_width   - width of a counter that runs 0 .. clks_per_bit-1
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baud);
        return clk_freq / baud;
    endfunction

    function automatic int unsigned calc_cnt_width(input int unsigned clks_per_bit);
        return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word fall-through FIFO with occupancy count.
//   clk_i, rst_ni - clock, synchronous active-low reset (empties the FIFO)
//   push_i/wdata_i - write request and data; ignored when full unless popping too
//   pop_i          - read request; ignored when empty
//   rdata_o        - current head, forced to zero when empty
//   empty_o/full_o - status
//   count_o        - registered occupancy, 0 .. Depth
// Depth must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FullCount);
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: full-duplex UART with an RX FIFO and a runtime echo mode.
//   CLOCK_50            - system clock
//   KEY                 - synchronous active-low reset
//   uart_rxd / uart_txd - serial line in / out, idle high
//   echo_en             - 1: FIFO drains into TX; 0: host valid/ready ports active
//   tx_data/tx_valid/tx_ready - host transmit handshake
//   rx_data/rx_valid/rx_ready - host receive handshake (FIFO head, fall-through)
//   rx_count            - FIFO occupancy
//   tx_busy             - frame in progress on uart_txd
//   frame_err, overrun  - sticky error flags, cleared by err_clr
// Build option: define UART_PARITY_EN to add the PARITY_ODD parameter, a parity
// bit on both directions and the sticky parity_err output.
module uart_fifo_bridge
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned STOP_BITS  = 1
`ifdef UART_PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic                          CLOCK_50,
    input  logic                          KEY,
    input  logic                          uart_rxd,
    output logic                          uart_txd,
    input  logic                          echo_en,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          tx_busy,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clr
`ifdef UART_PARITY_EN
    ,
    output logic                          parity_err
`endif
);

    localparam int unsigned ClksPerBit = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned CntW       = calc_cnt_width(ClksPerBit);
    localparam int unsigned BitW       = $clog2(DATA_BITS);

    localparam logic [CntW-1:0] BitEnd   = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] HalfEnd  = CntW'(ClksPerBit / 2 - 1);
    localparam logic [BitW-1:0] LastData = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);

    // ------------------------------------------------------------------
    // RX input synchroniser
    // ------------------------------------------------------------------
    logic rxd_meta_q;
    logic rxd_sync_q;

    always_ff @(posedge CLOCK_50) begin
        if (!KEY) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_push_q;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 fifo_pop;
    logic                 host_pop;
    logic                 echo_start;

    assign rx_valid = !fifo_empty && !echo_en;
    assign rx_data  = fifo_rdata;
    assign host_pop = rx_valid && rx_ready;
    assign fifo_pop = host_pop || echo_start;

    sync_fifo #(
        .Width (DATA_BITS),
        .Depth (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i   (CLOCK_50),
        .rst_ni  (KEY),
        .push_i  (rx_push_q),
        .wdata_i (rx_shift_q),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (rx_count)
    );

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    uart_state_e     rx_state_q;
    logic [CntW-1:0] rx_cnt_q;
    logic [BitW-1:0] rx_bit_q;
    logic            rx_par_ok_q;
    logic            rx_tick;

    assign rx_tick = (rx_cnt_q == BitEnd);

`ifdef UART_PARITY_EN
    logic rx_par_exp;
    assign rx_par_exp = (^rx_shift_q) ^ PARITY_ODD;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!KEY) begin
            rx_state_q  <= StIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_push_q   <= 1'b0;
            rx_par_ok_q <= 1'b1;
        end else begin
            rx_push_q <= 1'b0;
            unique case (rx_state_q)
                StIdle: begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= '0;
                    if (!rxd_sync_q) begin
                        rx_state_q <= StStart;
                    end
                end
                StStart: begin
                    // Mid-start sample; a high line here was only a glitch.
                    if (rx_cnt_q == HalfEnd) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= rxd_sync_q ? StIdle : StData;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (rx_tick) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == LastData) begin
`ifdef UART_PARITY_EN
                            rx_state_q <= StParity;
`else
                            rx_state_q <= StStop;
`endif
                        end else begin
                            rx_bit_q <= rx_bit_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                StParity: begin
                    if (rx_tick) begin
                        rx_cnt_q    <= '0;
                        rx_par_ok_q <= (rxd_sync_q == rx_par_exp);
                        rx_state_q  <= StStop;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
`endif
                StStop: begin
                    // Leave at mid-stop so the next start edge is caught early.
                    if (rx_tick) begin
                        rx_cnt_q    <= '0;
                        rx_push_q   <= rxd_sync_q && rx_par_ok_q;
                        rx_par_ok_q <= 1'b1;
                        rx_state_q  <= StIdle;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a new event wins over err_clr
    // ------------------------------------------------------------------
    logic frame_evt;
    logic overrun_evt;
    logic frame_err_q;
    logic overrun_q;

    assign frame_evt   = (rx_state_q == StStop) && rx_tick && !rxd_sync_q;
    assign overrun_evt = rx_push_q && fifo_full && !fifo_pop;

    always_ff @(posedge CLOCK_50) begin
        if (!KEY) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (frame_evt) begin
                frame_err_q <= 1'b1;
            end else if (err_clr) begin
                frame_err_q <= 1'b0;
            end
            if (overrun_evt) begin
                overrun_q <= 1'b1;
            end else if (err_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

`ifdef UART_PARITY_EN
    logic parity_evt;
    logic parity_err_q;

    assign parity_evt = (rx_state_q == StParity) && rx_tick && (rxd_sync_q != rx_par_exp);

    always_ff @(posedge CLOCK_50) begin
        if (!KEY) begin
            parity_err_q <= 1'b0;
        end else if (parity_evt) begin
            parity_err_q <= 1'b1;
        end else if (err_clr) begin
            parity_err_q <= 1'b0;
        end
    end

    assign parity_err = parity_err_q;
`endif

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    uart_state_e          tx_state_q;
    logic [CntW-1:0]      tx_cnt_q;
    logic [BitW-1:0]      tx_bit_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 txd_q;
    logic                 tx_busy_q;
    logic                 tx_idle_q;
    logic                 tx_tick;
    logic                 host_start;
    logic [DATA_BITS-1:0] tx_src;

    // tx_idle_q is low in reset so tx_ready stays low while KEY is held.
    assign tx_ready   = tx_idle_q && !echo_en;
    assign host_start = tx_ready && tx_valid;
    assign echo_start = tx_idle_q && echo_en && !fifo_empty;
    assign tx_src     = echo_start ? fifo_rdata : tx_data;
    assign tx_tick    = (tx_cnt_q == BitEnd);

`ifdef UART_PARITY_EN
    logic tx_par_q;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!KEY) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_idle_q  <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            unique case (tx_state_q)
                StIdle: begin
                    tx_cnt_q <= '0;
                    tx_bit_q <= '0;
                    if (echo_start || host_start) begin
                        tx_shift_q <= tx_src;
`ifdef UART_PARITY_EN
                        tx_par_q   <= (^tx_src) ^ PARITY_ODD;
`endif
                        txd_q      <= 1'b0;
                        tx_busy_q  <= 1'b1;
                        tx_idle_q  <= 1'b0;
                        tx_state_q <= StStart;
                    end else begin
                        tx_idle_q <= 1'b1;
                    end
                end
                StStart: begin
                    if (tx_tick) begin
                        tx_cnt_q   <= '0;
                        txd_q      <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_state_q <= StData;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (tx_tick) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == LastData) begin
                            tx_bit_q <= '0;
`ifdef UART_PARITY_EN
                            txd_q      <= tx_par_q;
                            tx_state_q <= StParity;
`else
                            txd_q      <= 1'b1;
                            tx_state_q <= StStop;
`endif
                        end else begin
                            tx_bit_q   <= tx_bit_q + 1'b1;
                            txd_q      <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                StParity: begin
                    if (tx_tick) begin
                        tx_cnt_q   <= '0;
                        txd_q      <= 1'b1;
                        tx_state_q <= StStop;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
`endif
                StStop: begin
                    // tx_bit_q counts stop bits here.
                    if (tx_tick) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == LastStop) begin
                            tx_bit_q   <= '0;
                            tx_busy_q  <= 1'b0;
                            tx_idle_q  <= 1'b1;
                            tx_state_q <= StIdle;
                        end else begin
                            tx_bit_q <= tx_bit_q + 1'b1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= StIdle;
            endcase
        end
    end

    assign uart_txd = txd_q;
    assign tx_busy  = tx_busy_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge: 10 clocks per bit, 8 data bits, 4-entry FIFO.
module tb_uart_fifo_bridge;

    localparam int unsigned ClkFreq   = 1000000;
    localparam int unsigned Baud      = 100000;
    localparam int unsigned DataBits  = 8;
    localparam int unsigned FifoDepth = 4;
    localparam int unsigned Cpb       = 10;

    logic       clk      = 1'b0;
    logic       key      = 1'b0;
    logic       rxd      = 1'b1;
    logic       echo_en  = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       rx_ready = 1'b0;
    logic       err_clr  = 1'b0;

    logic       uart_txd;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] rx_count;
    logic       tx_busy;
    logic       frame_err;
    logic       overrun;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    uart_fifo_bridge #(
        .CLK_FREQ   (ClkFreq),
        .BAUD       (Baud),
        .DATA_BITS  (DataBits),
        .FIFO_DEPTH (FifoDepth),
        .STOP_BITS  (1)
    ) dut (
        .CLOCK_50  (clk),
        .KEY       (key),
        .uart_rxd  (rxd),
        .uart_txd  (uart_txd),
        .echo_en   (echo_en),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_count  (rx_count),
        .tx_busy   (tx_busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr)
    );

    // Drive one serial frame on rxd, LSB first, with the chosen stop-bit level.
    task automatic send_byte(input logic [7:0] d, input logic stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (Cpb) @(negedge clk);
        end
        rxd = stop;
        repeat (Cpb) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic wait_rx_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rx_valid === 1'b1) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        key = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (uart_txd !== 1'b1) begin
            tests_failed++; $display("FAIL reset_txd: got %b want 1", uart_txd);
        end
        tests_run++;
        if (tx_busy !== 1'b0 || tx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_tx: busy=%b ready=%b want 0 0", tx_busy, tx_ready);
        end
        tests_run++;
        if (rx_valid !== 1'b0 || rx_count !== 3'd0 || rx_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_rx: valid=%b count=%0d data=%h want 0 0 00",
                     rx_valid, rx_count, rx_data);
        end
        tests_run++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: frame=%b overrun=%b want 0 0", frame_err, overrun);
        end
        key = 1'b1;
        @(negedge clk);
        tests_run++;
        if (tx_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_release_ready: got %b want 1", tx_ready);
        end
    endtask

    task automatic test_reset_mid_frame;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (30) @(negedge clk);
        tests_run++;
        if (tx_busy !== 1'b1 || uart_txd !== 1'b0) begin
            tests_failed++;
            $display("FAIL midframe_active: busy=%b txd=%b want 1 0", tx_busy, uart_txd);
        end
        key = 1'b0;
        @(negedge clk);
        tests_run++;
        if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midframe_abort: txd=%b busy=%b ready=%b want 1 0 0",
                     uart_txd, tx_busy, tx_ready);
        end
        tests_run++;
        if (rx_count !== 3'd0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL midframe_state: count=%0d frame=%b overrun=%b want 0 0 0",
                     rx_count, frame_err, overrun);
        end
        key = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_host_tx;
        logic [9:0] frame;
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 20; i++) begin
            if (tx_ready === 1'b1) break;
            @(negedge clk);
        end
        tests_run++;
        if (tx_ready !== 1'b1) begin
            tests_failed++; $display("FAIL host_tx_ready_idle: got %b want 1", tx_ready);
        end
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int k = 0; k < 10 * Cpb; k++) begin
            tests_run++;
            if (uart_txd !== frame[k / Cpb] || tx_ready !== 1'b0 || tx_busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL host_tx_bit cycle %0d: txd=%b ready=%b busy=%b want %b 0 1",
                         k, uart_txd, tx_ready, tx_busy, frame[k / Cpb]);
            end
            @(negedge clk);
        end
        tests_run++;
        if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL host_tx_end: txd=%b busy=%b ready=%b want 1 0 1",
                     uart_txd, tx_busy, tx_ready);
        end
    endtask

    task automatic test_rx_read;
        send_byte(8'h3C, 1'b1);
        wait_rx_valid(40);
        tests_run++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C || rx_count !== 3'd1) begin
            tests_failed++;
            $display("FAIL rx_read: valid=%b data=%h count=%0d want 1 3c 1",
                     rx_valid, rx_data, rx_count);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        tests_run++;
        if (rx_count !== 3'd0 || rx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rx_pop: count=%0d valid=%b want 0 0", rx_count, rx_valid);
        end
    endtask

    task automatic test_overrun;
        logic [7:0] b;
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            send_byte(b, 1'b1);
        end
        repeat (20) @(negedge clk);
        tests_run++;
        if (rx_count !== 3'd4 || overrun !== 1'b1 || rx_data !== 8'h01) begin
            tests_failed++;
            $display("FAIL overrun_set: count=%0d overrun=%b head=%h want 4 1 01",
                     rx_count, overrun, rx_data);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++; $display("FAIL overrun_clear: got %b want 0", overrun);
        end
        for (int i = 1; i <= 4; i++) begin
            b = 8'(i);
            tests_run++;
            if (rx_data !== b || rx_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL overrun_order %0d: data=%h valid=%b want %h 1",
                         i, rx_data, rx_valid, b);
            end
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
        tests_run++;
        if (rx_valid !== 1'b0 || rx_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL overrun_drained: valid=%b count=%0d want 0 0", rx_valid, rx_count);
        end
    endtask

    task automatic test_framing;
        send_byte(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        tests_run++;
        if (frame_err !== 1'b1 || rx_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL frame_err_set: frame=%b count=%0d want 1 0", frame_err, rx_count);
        end
        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        tests_run++;
        if (rx_count !== 3'd0 || rx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_ignored: count=%0d valid=%b want 0 0", rx_count, rx_valid);
        end
        send_byte(8'hAA, 1'b1);
        wait_rx_valid(40);
        tests_run++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hAA) begin
            tests_failed++;
            $display("FAIL after_glitch_rx: valid=%b data=%h want 1 aa", rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        err_clr  = 1'b1;
        @(negedge clk);
        err_clr  = 1'b0;
        tests_run++;
        if (frame_err !== 1'b0 || rx_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL frame_err_clear: frame=%b count=%0d want 0 0", frame_err, rx_count);
        end
    endtask

    task automatic test_echo;
        logic seen_valid;
        seen_valid = 1'b0;
        echo_en = 1'b1;
        @(negedge clk);
        fork
            begin
                send_byte(8'hC3, 1'b1);
                send_byte(8'h7E, 1'b1);
            end
            begin
                for (int f = 0; f < 2; f++) begin
                    int         waited;
                    logic [7:0] got;
                    logic [7:0] want;
                    waited = 0;
                    got    = 8'h00;
                    want   = (f == 0) ? 8'hC3 : 8'h7E;
                    while (uart_txd !== 1'b0 && waited < 400) begin
                        @(negedge clk);
                        waited++;
                    end
                    tests_run++;
                    if (uart_txd !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL echo_start %0d: txd=%b want 0 within 400 clks",
                                 f, uart_txd);
                    end
                    repeat (Cpb / 2) @(negedge clk);
                    for (int i = 0; i < 8; i++) begin
                        repeat (Cpb) @(negedge clk);
                        got[i] = uart_txd;
                    end
                    repeat (Cpb) @(negedge clk);
                    tests_run++;
                    if (uart_txd !== 1'b1 || got !== want) begin
                        tests_failed++;
                        $display("FAIL echo_byte %0d: data=%h stop=%b want %h 1",
                                 f, got, uart_txd, want);
                    end
                end
            end
            begin
                for (int c = 0; c < 450; c++) begin
                    @(negedge clk);
                    if (rx_valid !== 1'b0) seen_valid = 1'b1;
                end
            end
        join
        tests_run++;
        if (seen_valid !== 1'b0 || rx_count !== 3'd0 || tx_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL echo_end: rx_valid_seen=%b count=%0d busy=%b want 0 0 0",
                     seen_valid, rx_count, tx_busy);
        end
        echo_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid_frame();
        test_host_tx();
        test_rx_read();
        test_overrun();
        test_framing();
        test_echo();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
